mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-input, 1-bit `mux_4x1` datapath between four requesters. It grants one requester at a time and drives the mux select so that requester's data bit reaches a registered output. It bounds how long one owner can hold the mux while others wait. It sits directly in front of `mux_4x1`, which it instantiates, and replaces free-running select stimulus in systems where several agents contend for the single output line.

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/mux_rr_arbiter_if.sv | 26 ++
 rtl/mux_4x1.sv | 10 +
 rtl/mux_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the FSM encoding and the requester-to-select mapping.
package mux_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // mux_4x1 routes i[2*s[0]+s[1]], so the index bits are swapped onto s.
  function automatic logic [1:0] sel_of(input logic [1:0] n);
    return {n[0], n[1]};
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bus of the mux arbiter plus debug visibility of its state.
// Requesters (master) drive req/i; the arbiter (slave) returns gnt/s/y/valid.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       valid;
  arb_state_e dbg_state;
  logic [1:0] dbg_ptr;
  logic [3:0] dbg_hold;

  modport master (
    output req, i,
    input  gnt, s, y, valid, dbg_state, dbg_ptr, dbg_hold
  );

  modport slave (
    input  req, i,
    output gnt, s, y, valid, dbg_state, dbg_ptr, dbg_hold
  );

endinterface

// File: rtl/mux_4x1.sv
// 4-input, 1-bit combinational mux; select bit 0 is the high index bit.
module mux_4x1 (
  input  logic [3:0] i,
  input  logic [1:0] s,
  output logic       y
);

  assign y = i[{s[0], s[1]}];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4x1 among four requesters, with a
// bounded hold time and a registered data output.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux_rr_arbiter_if.slave  bus
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic       y_q, y_d;
  logic       valid_q, valid_d;

  logic       mux_y;
  logic [3:0] others;
  logic       keep;
  logic [2:0] win_idle;
  logic [2:0] win_rel;

  // Returns {found, index} of the first set bit of r searching upward from start.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + k[1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  mux_4x1 u_mux (
    .i (bus.i),
    .s (s_q),
    .y (mux_y)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    s_d      = s_q;
    others   = bus.req & ~(4'b0001 << owner_q);
    keep     = bus.req[owner_q] && ((hold_q < HOLD_LAST) || (others == 4'b0000));
    win_idle = pick(bus.req, ptr_q);
    // Searching from owner+1 visits the old owner last, so other requesters win first.
    win_rel  = pick(bus.req, owner_q + 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (win_idle[2]) begin
          state_d = ST_GRANT;
          owner_d = win_idle[1:0];
          hold_d  = 4'd0;
          gnt_d   = 4'b0001 << win_idle[1:0];
          s_d     = sel_of(win_idle[1:0]);
        end
      end
      ST_GRANT: begin
        if (keep) begin
          if (hold_q < HOLD_LAST) hold_d = hold_q + 4'd1;
        end else begin
          ptr_d = owner_q + 2'd1;
          if (win_rel[2]) begin
            owner_d = win_rel[1:0];
            hold_d  = 4'd0;
            gnt_d   = 4'b0001 << win_rel[1:0];
            s_d     = sel_of(win_rel[1:0]);
          end else begin
            state_d = ST_IDLE;
            hold_d  = 4'd0;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_q == ST_GRANT);
    y_d     = (state_q == ST_GRANT) ? mux_y : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
      s_q     <= 2'b00;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.s         = s_q;
  assign bus.y         = y_q;
  assign bus.valid     = valid_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;
  assign bus.dbg_hold  = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter: drivers push the expected
// {gnt,s,y,valid} after the next edge; a monitor pops and compares.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [1:0] sel_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  task automatic check(input string t, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", t, act, exp);
    end
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                      input logic [1:0] sv, input logic yv, input logic vv, input string t);
    @(negedge clk);
    bus.req = r;
    bus.i   = d;
    exp_q.push_back({g, sv, yv, vv});
    tag_q.push_back(t);
  endtask

  task automatic check_ptr(input logic [1:0] p, input string t);
    @(posedge clk);
    #2;
    check(t, {6'b0, bus.dbg_ptr}, {6'b0, p});
  endtask

  // monitor
  initial begin
    logic [7:0] e;
    logic [7:0] a;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {bus.gnt, bus.s, bus.y, bus.valid};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got gnt=%b s=%b y=%b valid=%b, want gnt=%b s=%b y=%b valid=%b",
                   t, a[7:4], a[3:2], a[1], a[0], e[7:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] iv;
    logic [3:0] oh;
    int         own;
    int         prv;
    int         wait_cnt;

    rst     = 1'b1;
    bus.req = 4'b0000;
    bus.i   = 4'b0000;
    #12;
    check("reset_outputs", {bus.gnt, bus.s, bus.y, bus.valid}, 8'b0000_00_0_0);
    check("reset_ptr", {6'b0, bus.dbg_ptr}, 8'd0);
    check("reset_hold", {4'b0, bus.dbg_hold}, 8'd0);
    check("reset_state", {7'b0, bus.dbg_state}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention: all four requesting, MAX_HOLD=4 -> four cycles each in turn.
    iv = 4'b0110;
    for (int c = 0; c < 18; c++) begin
      own = (c / 4) % 4;
      prv = (c > 0) ? ((c - 1) / 4) % 4 : 0;
      step(4'b1111, iv, 4'b0001 << own, sel_tab[own],
           (c > 0) ? iv[prv] : 1'b0, (c > 0), "contention");
    end
    step(4'b0000, iv, 4'b0000, 2'b00, 1'b0, 1'b1, "cont_release");
    check_ptr(2'd1, "cont_ptr");
    step(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, "cont_idle");

    // Single requester held well past MAX_HOLD.
    step(4'b0010, 4'b0010, 4'b0010, 2'b10, 1'b0, 1'b0, "single_gnt");
    for (int k = 0; k < 6; k++)
      step(4'b0010, 4'b0010, 4'b0010, 2'b10, 1'b1, 1'b1, "single_hold");
    step(4'b0000, 4'b0010, 4'b0000, 2'b10, 1'b1, 1'b1, "single_release");
    step(4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0, "single_idle");

    // Data routing through each requester.
    for (int n = 0; n < 4; n++) begin
      oh = 4'b0001 << n;
      step(oh, oh, oh, sel_tab[n], 1'b0, 1'b0, "route_gnt");
      step(oh, oh, oh, sel_tab[n], 1'b1, 1'b1, "route_y1");
      step(oh, ~oh, oh, sel_tab[n], 1'b0, 1'b1, "route_y0");
      step(4'b0000, 4'b0000, 4'b0000, sel_tab[n], 1'b0, 1'b1, "route_release");
      step(4'b0000, 4'b0000, 4'b0000, sel_tab[n], 1'b0, 1'b0, "route_idle");
    end

    // Early drop of owner 0 hands over to requester 2 without an idle cycle.
    step(4'b0101, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0, "drop_gnt0");
    step(4'b0101, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1, "drop_hold");
    step(4'b0100, 4'b0001, 4'b0100, 2'b01, 1'b1, 1'b1, "drop_move");
    check_ptr(2'd1, "drop_ptr");
    step(4'b0000, 4'b0001, 4'b0000, 2'b01, 1'b0, 1'b1, "drop_release");
    step(4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0, "drop_idle");

    // Pointer wrap: owner 3 expires, 0 wins, then 3 comes back.
    step(4'b1000, 4'b1010, 4'b1000, 2'b11, 1'b0, 1'b0, "wrap_gnt3");
    for (int k = 0; k < 3; k++)
      step(4'b1001, 4'b1010, 4'b1000, 2'b11, 1'b1, 1'b1, "wrap_hold");
    step(4'b1001, 4'b1010, 4'b0001, 2'b00, 1'b1, 1'b1, "wrap_expire");
    check_ptr(2'd0, "wrap_ptr");
    step(4'b1000, 4'b1010, 4'b1000, 2'b11, 1'b0, 1'b1, "wrap_back3");
    step(4'b0000, 4'b1010, 4'b0000, 2'b11, 1'b1, 1'b1, "wrap_release");
    step(4'b0000, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0, "wrap_idle");

    // Asynchronous reset in the middle of a grant.
    step(4'b0100, 4'b0100, 4'b0100, 2'b01, 1'b0, 1'b0, "rst_pre_gnt");
    step(4'b0100, 4'b0100, 4'b0100, 2'b01, 1'b1, 1'b1, "rst_pre_y");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_outputs", {bus.gnt, bus.s, bus.y, bus.valid}, 8'b0000_00_0_0);
    check("rst_async_ptr", {6'b0, bus.dbg_ptr}, 8'd0);
    check("rst_async_state", {7'b0, bus.dbg_state}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b0100, 4'b0000, 4'b0100, 2'b01, 1'b0, 1'b0, "post_rst_gnt");
    step(4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b1, "post_rst_release");
    step(4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0, "post_rst_idle");

    // drain the scoreboard, bounded
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
